sub8_serial: RTL and testbench

//  Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.

---
 rtl/sub8_serial.sv | 93 +++++++++
 tb/tb_sub8_serial.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sub8_serial.sv
// rtl/sub8_serial.sv - bit-serial two's-complement subtractor, LSB first, start/busy/done handshake
module sub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             ovfl,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit;
  logic             c_next;

  // One full-adder slice computing a + ~b + carry on the current LSBs
  always_comb begin
    s_bit  = sa[0] ^ ~sb[0] ^ carry;
    c_next = (sa[0] & ~sb[0]) | (sa[0] & carry) | (~sb[0] & carry);
  end

  // Handshake FSM with the serial datapath; diff doubles as the result shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      carry <= 1'b1;
      diff  <= '0;
      ovfl  <= 1'b0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // carry-in of 1 completes the two's complement of b
            sa    <= a;
            sb    <= b;
            carry <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          diff  <= {s_bit, diff[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry holds the carry into the MSB, c_next the carry out
            ovfl  <= carry ^ c_next;
            bout  <= ~c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub8_serial.sv
// tb/tb_sub8_serial.sv - self-checking bench for sub8_serial against an arithmetic model
module tb_sub8_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         ovfl;
  logic         bout;
  logic         busy;
  logic         done;

  int n_vec;
  int n_err;

  sub8_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .diff (diff),
    .ovfl (ovfl),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, signed range test, unsigned compare
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int          sd;
    logic [31:0] ud;
    logic        ov;
    logic        bo;
    ud = 32'(int'(x) - int'(y));
    sd = int'($signed(x)) - int'($signed(y));
    ov = (sd > 127) || (sd < -128);
    bo = (x < y);
    return {ov, bo, ud[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge; counts cycles to done
  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k <= 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+1:0] r;
    r = ref_sub(x, y);
    check({tag, ".diff"}, 32'(diff), 32'(r[W-1:0]));
    check({tag, ".bout"}, 32'(bout), 32'(r[W]));
    check({tag, ".ovfl"}, 32'(ovfl), 32'(r[W+1]));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(k);
    check({tag, ".latency"}, 32'(k), 32'(W));
    check_result(tag, x, y);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
    check_result({tag, ".held"}, x, y);
  endtask

  initial begin
    int k;
    int seen;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset.diff", 32'(diff), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.flags", {30'd0, ovfl, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("d0", 8'h05, 8'h03);
    run_op("d1", 8'h03, 8'h05);
    run_op("d2", 8'h80, 8'h01);
    run_op("d3", 8'h7F, 8'hFF);
    run_op("d4", 8'h00, 8'h00);
    run_op("d5", 8'h00, 8'h80);

    // start during RUN is ignored, then start held through DONE chains a second op
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h20;
    b = 8'h30;
    start = 1'b1;
    k = 4;
    while (done !== 1'b1 && k <= 20) begin
      @(negedge clk);
      k++;
    end
    check("ign.latency", 32'(k), 32'(W));
    check_result("ign", 8'h10, 8'h01);
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.done", 32'(done), 32'd0);
    wait_done(k);
    check("b2b.latency", 32'(k), 32'(W));
    check_result("b2b", 8'h20, 8'h30);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 8'hC3;
    b = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstrun.diff", 32'(diff), 32'd0);
    check("rstrun.busy", 32'(busy), 32'd0);
    check("rstrun.done", 32'(done), 32'd0);
    check("rstrun.flags", {30'd0, ovfl, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("rstrun.nodone", 32'(seen), 32'd0);
    run_op("post", 8'h05, 8'h03);

    // randomized operands against the model
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
